// File: rtl/anim_sequencer.sv
// Playlist controller for the LED animation mux: steps through the animation modes
// with a per-mode dwell time, a blanked gap between patterns and manual next/prev.
module anim_sequencer #(
    parameter int unsigned NUM_MODES     = 5,
    parameter int unsigned TICK_DIV      = 1_000_000,
    parameter logic [7:0]  DWELL_DEFAULT = 8'd20,
    parameter int unsigned BLANK_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       auto_en,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_dwell,
    output logic [2:0] mode,
    output logic       en,
    output logic       wrap
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS + 1) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [2:0]    LAST_MODE  = 3'(NUM_MODES - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_TICKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic            en_q, en_d;
    logic            wrap_q, wrap_d;
    logic [7:0]      dwell_cnt_q, dwell_cnt_d;
    logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
    logic [PW-1:0]   presc_q;
    logic            next_q, prev_q;
    logic [7:0]      dwell_q [8];

    logic            tick;
    logic            next_edge, prev_edge;
    logic            step_fwd, step_bwd, step;
    logic [2:0]      mode_nxt, mode_prv, step_mode;
    logic            go_gap;

    assign tick      = (presc_q == TICK_LAST);
    assign next_edge = btn_next & ~next_q;
    assign prev_edge = btn_prev & ~prev_q;
    // Simultaneous next and prev edges cancel each other.
    assign step_fwd  = next_edge & ~prev_edge;
    assign step_bwd  = prev_edge & ~next_edge;
    assign step      = step_fwd | step_bwd;
    assign mode_nxt  = (mode_q == LAST_MODE) ? 3'd0 : mode_q + 3'd1;
    assign mode_prv  = (mode_q == 3'd0) ? LAST_MODE : mode_q - 3'd1;
    assign step_mode = step_fwd ? mode_nxt : mode_prv;

    // Prescaler, button edge registers and dwell table.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            next_q  <= 1'b0;
            prev_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                dwell_q[i] <= DWELL_DEFAULT;
            end
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            next_q  <= btn_next;
            prev_q  <= btn_prev;
            if (cfg_we && (32'(cfg_addr) < NUM_MODES)) begin
                dwell_q[cfg_addr] <= cfg_dwell;
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 3'd0;
            en_q        <= 1'b0;
            wrap_q      <= 1'b0;
            dwell_cnt_q <= 8'd0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            wrap_q      <= wrap_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wrap_d      = 1'b0;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        go_gap      = 1'b0;

        case (state_q)
            IDLE: begin
                if (step) begin
                    mode_d = step_mode;
                end
                if (run) begin
                    state_d     = SHOW;
                    dwell_cnt_d = dwell_q[mode_d];
                end
            end
            SHOW: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (step) begin
                    mode_d = step_mode;
                    go_gap = 1'b1;
                end else if (auto_en && tick && (dwell_q[mode_q] != 8'd0)
                             && (dwell_cnt_q != 8'd0)) begin
                    if (dwell_cnt_q == 8'd1) begin
                        mode_d = mode_nxt;
                        wrap_d = (mode_q == LAST_MODE);
                        go_gap = 1'b1;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 8'd1;
                    end
                end
            end
            BLANK: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (step) begin
                    mode_d      = step_mode;
                    blank_cnt_d = BLANK_LOAD;
                end else if (tick) begin
                    if (blank_cnt_q <= BW'(1)) begin
                        state_d     = SHOW;
                        blank_cnt_d = '0;
                        dwell_cnt_d = dwell_q[mode_q];
                    end else begin
                        blank_cnt_d = blank_cnt_q - BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Leaving a pattern: blank gap, or reload straight into the next pattern.
        if (go_gap) begin
            if (BLANK_TICKS == 0) begin
                state_d     = SHOW;
                dwell_cnt_d = dwell_q[mode_d];
            end else begin
                state_d     = BLANK;
                blank_cnt_d = BLANK_LOAD;
            end
        end

        en_d = (state_d == SHOW);
    end

    assign mode = mode_q;
    assign en   = en_q;
    assign wrap = wrap_q;

endmodule
